// File: rtl/iob_resp.sv
// iob_resp: PDS-side 68000 bus responder terminating IOB cycles with nDTACK, nVPA or nBERR.
// Define IOB_RESP_BERR_EN to time out unmapped addresses to nBERR; otherwise they take the nDTACK path.
module iob_resp #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned TIMEOUT  = 200,
  parameter logic [2:0]  DT_TOP   = 3'h5,
  parameter logic [2:0]  VPA_SEL  = 3'h7
) (
  input  logic        C16M,
  input  logic        nRES,
  input  logic [23:1] A_IOB,
  input  logic        nAS_IOB,
  input  logic        nUDS_IOB,
  input  logic        nLDS_IOB,
  input  logic        nWE_IOB,
  input  logic        nVMA_IOB,
  input  logic        E,
  output logic        nDTACK,
  output logic        nVPA,
  output logic        nBERR,
  output logic        RdOE,
  output logic        WrLE,
  output logic        WrU,
  output logic        WrL
);

  localparam logic [7:0] LP_WAIT = 8'(WAIT_CYC);
`ifdef IOB_RESP_BERR_EN
  localparam logic [7:0] LP_TOUT = 8'(TIMEOUT);
`endif

  // Synchronizer order {nAS, nUDS, nLDS, nVMA, E}. nAS resets to its asserted level so a
  // cycle already in flight at reset release never looks negated and cannot set ARM.
  localparam logic [4:0] LP_SYNC_RST = 5'b01110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_VPA,
`ifdef IOB_RESP_BERR_EN
    S_TOUT,
`endif
    S_TERM
  } state_t;

  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic       r_e_d;

  state_t     r_state;
  logic       r_arm;
  logic [7:0] r_cnt;
  logic       r_write;
  logic       r_vma_seen;
  logic       r_ndtack;
  logic       r_nvpa;
  logic       r_rdoe;
  logic       r_wrle;
  logic       r_wru;
  logic       r_wrl;
`ifdef IOB_RESP_BERR_EN
  logic       r_nberr;
`endif

  logic w_as;
  logic w_uds;
  logic w_lds;
  logic w_vma;
  logic w_efall;
  logic w_abort;
  logic w_unused;

  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      r_sync1 <= LP_SYNC_RST;
      r_sync2 <= LP_SYNC_RST;
      r_e_d   <= 1'b0;
    end else begin
      r_sync1 <= {nAS_IOB, nUDS_IOB, nLDS_IOB, nVMA_IOB, E};
      r_sync2 <= r_sync1;
      r_e_d   <= r_sync2[0];
    end
  end

  assign w_as    = !r_sync2[4];
  assign w_uds   = !r_sync2[3];
  assign w_lds   = !r_sync2[2];
  assign w_vma   = !r_sync2[1];
  assign w_efall = r_e_d && !r_sync2[0];
  assign w_abort = !w_as && (r_state != S_IDLE) && (r_state != S_TERM);

  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      r_state    <= S_IDLE;
      r_arm      <= 1'b0;
      r_cnt      <= 8'd0;
      r_write    <= 1'b0;
      r_vma_seen <= 1'b0;
      r_ndtack   <= 1'b1;
      r_nvpa     <= 1'b1;
      r_rdoe     <= 1'b0;
      r_wrle     <= 1'b0;
      r_wru      <= 1'b0;
      r_wrl      <= 1'b0;
`ifdef IOB_RESP_BERR_EN
      r_nberr    <= 1'b1;
`endif
    end else begin
      r_wrle <= 1'b0;
      r_wru  <= 1'b0;
      r_wrl  <= 1'b0;
      if (!w_as) begin
        r_arm <= 1'b1;
      end
      // Abort and normal TERM exit share the same release: every termination drops together.
      if (w_abort || ((r_state == S_TERM) && !w_as)) begin
        r_state  <= S_IDLE;
        r_ndtack <= 1'b1;
        r_nvpa   <= 1'b1;
        r_rdoe   <= 1'b0;
`ifdef IOB_RESP_BERR_EN
        r_nberr  <= 1'b1;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_as && r_arm) begin
              r_state <= S_DECODE;
              r_rdoe  <= nWE_IOB;
            end
          end
          S_DECODE: begin
            r_write    <= !nWE_IOB;
            r_cnt      <= 8'd0;
            r_vma_seen <= 1'b0;
            if (A_IOB[23:21] <= DT_TOP) begin
              r_state <= S_WAIT;
            end else if (A_IOB[23:21] == VPA_SEL) begin
              r_state <= S_VPA;
              r_nvpa  <= 1'b0;
            end
`ifdef IOB_RESP_BERR_EN
            else begin
              r_state <= S_TOUT;
            end
`else
            else begin
              r_state <= S_WAIT;
            end
`endif
          end
          // Count stops at WAIT_CYC, so a write still waiting for a data strobe holds there.
          S_WAIT: begin
            if (r_cnt == LP_WAIT) begin
              if (!r_write || w_uds || w_lds) begin
                r_ndtack <= 1'b0;
                r_wrle   <= r_write;
                r_wru    <= r_write && w_uds;
                r_wrl    <= r_write && w_lds;
                r_state  <= S_TERM;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_VPA: begin
            if (w_vma) begin
              r_vma_seen <= 1'b1;
            end
            if (r_vma_seen && w_efall) begin
              r_wrle  <= r_write;
              r_wru   <= r_write && w_uds;
              r_wrl   <= r_write && w_lds;
              r_state <= S_TERM;
            end
          end
`ifdef IOB_RESP_BERR_EN
          S_TOUT: begin
            if ((r_cnt + 8'd1) == LP_TOUT) begin
              r_nberr <= 1'b0;
              r_state <= S_TERM;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
`endif
          S_TERM: begin
            r_state <= S_TERM;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign nDTACK = r_ndtack;
  assign nVPA   = r_nvpa;
  assign RdOE   = r_rdoe;
  assign WrLE   = r_wrle;
  assign WrU    = r_wru;
  assign WrL    = r_wrl;

`ifdef IOB_RESP_BERR_EN
  assign nBERR    = r_nberr;
  assign w_unused = &{1'b0, A_IOB[20:1]};
`else
  assign nBERR    = 1'b1;
  assign w_unused = &{1'b0, A_IOB[20:1], 8'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_iob_resp.sv
// tb_iob_resp: directed bus cycles against iob_resp with hand-computed latencies.
// Latencies count C16M rising edges after the stimulus change made at a falling edge.
module tb_iob_resp;

  logic        C16M;
  logic        nRES;
  logic [23:1] A_IOB;
  logic        nAS_IOB;
  logic        nUDS_IOB;
  logic        nLDS_IOB;
  logic        nWE_IOB;
  logic        nVMA_IOB;
  logic        E;
  logic        nDTACK;
  logic        nVPA;
  logic        nBERR;
  logic        RdOE;
  logic        WrLE;
  logic        WrU;
  logic        WrL;

  int checkCount  = 0;
  int failCount   = 0;
  int wrleCycles  = 0;
  int dtackCycles = 0;
  int multiCount  = 0;
  int lat;

  iob_resp dut (
    .C16M     (C16M),
    .nRES     (nRES),
    .A_IOB    (A_IOB),
    .nAS_IOB  (nAS_IOB),
    .nUDS_IOB (nUDS_IOB),
    .nLDS_IOB (nLDS_IOB),
    .nWE_IOB  (nWE_IOB),
    .nVMA_IOB (nVMA_IOB),
    .E        (E),
    .nDTACK   (nDTACK),
    .nVPA     (nVPA),
    .nBERR    (nBERR),
    .RdOE     (RdOE),
    .WrLE     (WrLE),
    .WrU      (WrU),
    .WrL      (WrL)
  );

  initial C16M = 1'b0;
  always #5 C16M = ~C16M;

  // Running tallies sampled just after each falling edge, well clear of the active edge.
  always @(negedge C16M) begin
    #1;
    if (WrLE) wrleCycles++;
    if (!nDTACK) dtackCycles++;
    if ((int'(!nDTACK) + int'(!nVPA) + int'(!nBERR)) > 1) multiCount++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic getOut(input int sel);
    case (sel)
      0:       return nDTACK;
      1:       return nVPA;
      2:       return nBERR;
      default: return !WrLE;
    endcase
  endfunction

  // Returns the number of rising edges until the selected output reaches level, or -1.
  task automatic waitFor(input int sel, input logic level, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge C16M);
      if (getOut(sel) == level) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge C16M);
  endtask

  task automatic clearMonitors();
    wrleCycles  = 0;
    dtackCycles = 0;
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic weN, input logic udsN,
                               input logic ldsN);
    A_IOB    = addr[23:1];
    nWE_IOB  = weN;
    nUDS_IOB = udsN;
    nLDS_IOB = ldsN;
    nAS_IOB  = 1'b0;
  endtask

  task automatic releaseBus();
    nAS_IOB  = 1'b1;
    nUDS_IOB = 1'b1;
    nLDS_IOB = 1'b1;
    nWE_IOB  = 1'b1;
  endtask

  initial begin
    nRES     = 1'b0;
    A_IOB    = '0;
    nAS_IOB  = 1'b1;
    nUDS_IOB = 1'b1;
    nLDS_IOB = 1'b1;
    nWE_IOB  = 1'b1;
    nVMA_IOB = 1'b1;
    E        = 1'b1;
    stepCycles(2);
    checkOutput("reset_state", int'({nDTACK, nVPA, nBERR, RdOE, WrLE, WrU, WrL}), 7'b1110000);
    nRES = 1'b1;
    stepCycles(5);

    // Read in the DTACK region: 2 sync + accept + decode + (WAIT_CYC+1) wait edges.
    clearMonitors();
    applyStimulus(24'h400000, 1'b1, 1'b0, 1'b0);
    waitFor(0, 1'b0, 50, lat);
    checkOutput("rd_dtack_lat", lat, 7);
    checkOutput("rd_rdoe", int'(RdOE), 1);
    stepCycles(3);
    checkOutput("rd_dtack_hold", int'(nDTACK), 0);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("rd_release_lat", lat, 3);
    checkOutput("rd_rdoe_off", int'(RdOE), 0);
    checkOutput("rd_no_wrle", wrleCycles, 0);
    stepCycles(3);

    // Word write: one WrLE pulse alongside nDTACK, both lanes.
    clearMonitors();
    applyStimulus(24'h000100, 1'b0, 1'b0, 1'b0);
    waitFor(0, 1'b0, 50, lat);
    checkOutput("wr_dtack_lat", lat, 7);
    checkOutput("wr_wrle_coinc", int'(WrLE), 1);
    checkOutput("wr_lanes", int'({WrU, WrL}), 3);
    checkOutput("wr_rdoe", int'(RdOE), 0);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("wr_release_lat", lat, 3);
    checkOutput("wr_one_pulse", wrleCycles, 1);
    stepCycles(3);

    // Byte write in the VPA region; E falls before and together with nVMA do not complete.
    clearMonitors();
    applyStimulus(24'hEFE1FE, 1'b0, 1'b1, 1'b0);
    waitFor(1, 1'b0, 50, lat);
    checkOutput("vpa_assert_lat", lat, 4);
    E = 1'b0;
    stepCycles(6);
    checkOutput("vpa_efall_no_vma", wrleCycles, 0);
    E = 1'b1;
    stepCycles(4);
    nVMA_IOB = 1'b0;
    E        = 1'b0;
    stepCycles(6);
    checkOutput("vpa_same_cycle_fall", wrleCycles, 0);
    checkOutput("vpa_hold", int'(nVPA), 0);
    E = 1'b1;
    stepCycles(4);
    E = 1'b0;
    waitFor(3, 1'b0, 20, lat);
    checkOutput("vpa_wrle_lat", lat, 3);
    checkOutput("vpa_lanes", int'({WrU, WrL}), 1);
    releaseBus();
    waitFor(1, 1'b1, 20, lat);
    checkOutput("vpa_release_lat", lat, 3);
    checkOutput("vpa_no_dtack", dtackCycles, 0);
    checkOutput("vpa_one_pulse", wrleCycles, 1);
    nVMA_IOB = 1'b1;
    E        = 1'b1;
    stepCycles(3);

    // Unmapped read: nBERR after TIMEOUT cycles past DECODE, or nDTACK when the timeout is not built.
    clearMonitors();
    applyStimulus(24'hC00000, 1'b1, 1'b0, 1'b0);
`ifdef IOB_RESP_BERR_EN
    waitFor(2, 1'b0, 300, lat);
    checkOutput("unmap_berr_lat", lat, 204);
    checkOutput("unmap_no_dtack", dtackCycles, 0);
    releaseBus();
    waitFor(2, 1'b1, 20, lat);
    checkOutput("unmap_release_lat", lat, 3);
`else
    waitFor(0, 1'b0, 50, lat);
    checkOutput("unmap_dtack_lat", lat, 7);
    checkOutput("unmap_no_berr", int'(nBERR), 1);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("unmap_release_lat", lat, 3);
`endif
    stepCycles(3);

    // Reset mid-WAIT with nAS still low: outputs drop at once and the in-flight cycle is dropped.
    clearMonitors();
    applyStimulus(24'h400000, 1'b1, 1'b0, 1'b0);
    stepCycles(5);
    checkOutput("pre_reset_rdoe", int'(RdOE), 1);
    #2;
    nRES = 1'b0;
    #1;
    checkOutput("mid_reset_outputs", int'({nDTACK, nVPA, nBERR, RdOE, WrLE, WrU, WrL}), 7'b1110000);
    @(negedge C16M);
    nRES = 1'b1;
    stepCycles(20);
    checkOutput("rst_drop_dtack", dtackCycles, 0);
    checkOutput("rst_drop_rdoe", int'(RdOE), 0);
    releaseBus();
    stepCycles(4);
    applyStimulus(24'h400000, 1'b1, 1'b0, 1'b0);
    waitFor(0, 1'b0, 50, lat);
    checkOutput("post_reset_lat", lat, 7);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("post_reset_release", lat, 3);
    stepCycles(3);

    // Write aborted during WAIT, then an immediate write that completes.
    clearMonitors();
    applyStimulus(24'h000100, 1'b0, 1'b0, 1'b0);
    stepCycles(3);
    releaseBus();
    stepCycles(10);
    checkOutput("abort_no_dtack", dtackCycles, 0);
    checkOutput("abort_no_wrle", wrleCycles, 0);
    applyStimulus(24'h000100, 1'b0, 1'b0, 1'b0);
    waitFor(0, 1'b0, 50, lat);
    checkOutput("after_abort_lat", lat, 7);
    checkOutput("after_abort_wrle", int'(WrLE), 1);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("after_abort_release", lat, 3);
    stepCycles(3);

    // Write with no data strobe holds in WAIT until LDS arrives.
    clearMonitors();
    applyStimulus(24'h000200, 1'b0, 1'b1, 1'b1);
    stepCycles(12);
    checkOutput("nods_hold", dtackCycles, 0);
    nLDS_IOB = 1'b0;
    waitFor(0, 1'b0, 20, lat);
    checkOutput("nods_ds_lat", lat, 3);
    checkOutput("nods_wrle", int'(WrLE), 1);
    checkOutput("nods_lanes", int'({WrU, WrL}), 1);
    releaseBus();
    waitFor(0, 1'b1, 20, lat);
    checkOutput("nods_release", lat, 3);
    stepCycles(3);

    checkOutput("one_termination", multiCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
